// File: rtl/uart_debugger.sv
// Debug telemetry port: periodically snapshots a wide debug bus and streams it out as
// UART 8N1 bytes, and receives single-byte 8N1 commands presented with a one-cycle strobe.
module uart_debugger #(
  parameter int DIVIDER_TICKS_WIDTH     = 20,
  parameter int DIVIDER_TICKS           = 727273,
  parameter int DATA_WIDTH_BASE2        = 8,
  parameter int DATA_WIDTH              = 192,
  parameter int UART_TICKS_PER_BIT      = 139,
  parameter int UART_TICKS_PER_BIT_SIZE = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  debug_uart_rx_in,
  output logic [7:0]            debug_command,
  output logic                  debug_command_pulse,
  output logic                  debug_command_busy,
  output logic                  tx_out
);

  localparam int TW = UART_TICKS_PER_BIT_SIZE;
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(UART_TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(UART_TICKS_PER_BIT / 2 - 1);
  localparam logic [DIVIDER_TICKS_WIDTH-1:0] DIV_LAST = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
  localparam logic [DATA_WIDTH_BASE2-1:0] LAST_BYTE = DATA_WIDTH_BASE2'(DATA_WIDTH / 8 - 1);

  logic [DIVIDER_TICKS_WIDTH-1:0] r_div;
  logic                           w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk_in) begin
    if (reset || w_tick) r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t                   r_tx_state;
  logic [DATA_WIDTH-1:0]       r_shadow;
  logic [TW-1:0]               r_tx_timer;
  logic [3:0]                  r_tx_phase;   // 0 start, 1..8 data, 9 stop
  logic [DATA_WIDTH_BASE2-1:0] r_tx_left;    // bytes still to send after the current one
  logic [7:0]                  w_tx_byte;

  assign w_tx_byte = r_shadow[DATA_WIDTH-1 -: 8];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_shadow   <= '0;
      r_tx_timer <= '0;
      r_tx_phase <= '0;
      r_tx_left  <= '0;
      tx_out     <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tick) begin
            r_shadow   <= data_in;
            r_tx_timer <= BIT_RELOAD;
            r_tx_phase <= 4'd0;
            r_tx_left  <= LAST_BYTE;
            tx_out     <= 1'b0;
            r_tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (r_tx_timer != '0) begin
            r_tx_timer <= r_tx_timer - 1'b1;
          end else begin
            r_tx_timer <= BIT_RELOAD;
            if (r_tx_phase == 4'd9) begin
              if (r_tx_left == '0) begin
                tx_out     <= 1'b1;
                r_tx_state <= TX_IDLE;
              end else begin
                // next byte follows the stop bit with no gap
                r_tx_left  <= r_tx_left - 1'b1;
                r_shadow   <= {r_shadow[DATA_WIDTH-9:0], 8'h00};
                r_tx_phase <= 4'd0;
                tx_out     <= 1'b0;
              end
            end else begin
              r_tx_phase <= r_tx_phase + 4'd1;
              tx_out     <= (r_tx_phase == 4'd8) ? 1'b1 : w_tx_byte[r_tx_phase[2:0]];
            end
          end
        end
      endcase
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t     r_rx_state;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic [TW-1:0] r_rx_timer;
  logic [2:0]    r_rx_bits;
  logic [7:0]    r_rx_shift;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rx_meta           <= 1'b1;
      r_rx_sync           <= 1'b1;
      r_rx_state          <= RX_IDLE;
      r_rx_timer          <= '0;
      r_rx_bits           <= '0;
      r_rx_shift          <= '0;
      debug_command       <= 8'h00;
      debug_command_pulse <= 1'b0;
      debug_command_busy  <= 1'b0;
    end else begin
      r_rx_meta           <= debug_uart_rx_in;
      r_rx_sync           <= r_rx_meta;
      debug_command_pulse <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_timer         <= HALF_RELOAD;
            debug_command_busy <= 1'b1;
            r_rx_state         <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_timer != '0) begin
            r_rx_timer <= r_rx_timer - 1'b1;
          end else if (r_rx_sync) begin
            debug_command_busy <= 1'b0;
            r_rx_state         <= RX_IDLE;
          end else begin
            r_rx_timer <= BIT_RELOAD;
            r_rx_bits  <= 3'd0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_timer != '0) begin
            r_rx_timer <= r_rx_timer - 1'b1;
          end else begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_timer <= BIT_RELOAD;
            if (r_rx_bits == 3'd7) r_rx_state <= RX_STOP;
            else                   r_rx_bits  <= r_rx_bits + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_timer != '0) begin
            r_rx_timer <= r_rx_timer - 1'b1;
          end else begin
            debug_command_busy <= 1'b0;
            if (r_rx_sync) begin
              debug_command       <= r_rx_shift;
              debug_command_pulse <= 1'b1;
              r_rx_state          <= RX_IDLE;
            end else begin
              r_rx_state <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // framing error: hold off until the line idles so the low stop bit is not a new start
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debugger.sv
// Self-checking bench for uart_debugger: TX frames decoded against the 8N1 bit rules,
// RX commands driven as 8N1 waveforms and checked against an expected-command model.
module tb_uart_debugger;
  localparam int DW = 16;
  localparam int T = 4;
  localparam int DIV = 100;
  localparam int DIV50 = 50;
  localparam int NB = DW / 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_in50 = '0;
  logic          rx_in = 1'b1;
  logic [7:0]    cmd, cmd50;
  logic          pulse, pulse50, busy, busy50, tx, tx50;

  uart_debugger #(
    .DIVIDER_TICKS_WIDTH(8), .DIVIDER_TICKS(DIV), .DATA_WIDTH_BASE2(5),
    .DATA_WIDTH(DW), .UART_TICKS_PER_BIT(T), .UART_TICKS_PER_BIT_SIZE(4)
  ) u_dut (
    .clk_in(clk_in), .reset(reset), .data_in(data_in), .debug_uart_rx_in(rx_in),
    .debug_command(cmd), .debug_command_pulse(pulse), .debug_command_busy(busy), .tx_out(tx)
  );

  uart_debugger #(
    .DIVIDER_TICKS_WIDTH(8), .DIVIDER_TICKS(DIV50), .DATA_WIDTH_BASE2(5),
    .DATA_WIDTH(DW), .UART_TICKS_PER_BIT(T), .UART_TICKS_PER_BIT_SIZE(4)
  ) u_dut50 (
    .clk_in(clk_in), .reset(reset), .data_in(data_in50), .debug_uart_rx_in(1'b1),
    .debug_command(cmd50), .debug_command_pulse(pulse50), .debug_command_busy(busy50),
    .tx_out(tx50)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int cyc_rel = 0;
  always @(posedge clk_in) cyc = cyc + 1;

  int   n_pulse = 0, n_wide = 0;
  int   pulse_cyc = -1000, rise_cyc = -1000, fall_cyc = -1000;
  logic prev_busy = 1'b0, prev_pulse = 1'b0, busy_before_pulse = 1'b0;
  int   starts50[$];
  int   hi50 = 1000;
  logic prev50 = 1'b1;

  always @(negedge clk_in) begin
    if (pulse) begin
      n_pulse++;
      pulse_cyc = cyc;
      busy_before_pulse = prev_busy;
      if (prev_pulse) n_wide++;
    end
    if (busy && !prev_busy) rise_cyc = cyc;
    if (!busy && prev_busy) fall_cyc = cyc;
    prev_busy  = busy;
    prev_pulse = pulse;
    // u_dut50 streams zero bytes, so only a frame start follows a long high run
    if (!tx50 && prev50 && hi50 > 2 * T) starts50.push_back(cyc - cyc_rel);
    hi50   = tx50 ? hi50 + 1 : 0;
    prev50 = tx50;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int n);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (n) @(negedge clk_in);
    reset = 1'b0;
    cyc_rel = cyc;
    starts50.delete();
  endtask

  task automatic wait_tx_start(output int at);
    int k = 0;
    while (tx !== 1'b0 && k < 400) begin
      @(negedge clk_in);
      k++;
    end
    at = cyc - cyc_rel;
    check("tx_start_seen", 64'(tx), 64'(0));
  endtask

  // Called at the negedge where the start bit first shows; checks every cycle of the frame.
  task automatic capture_frame(input logic [DW-1:0] v, input string tag);
    logic [63:0] obs, exp_w;
    logic [7:0]  b;
    int          bi;
    for (int j = 0; j < NB; j++) begin
      obs = '0;
      exp_w = '0;
      b = v[DW-1-8*j -: 8];
      for (int k = 0; k < 10 * T; k++) begin
        if (j != 0 || k != 0) @(negedge clk_in);
        obs[k] = tx;
        bi = k / T;
        exp_w[k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      end
      check($sformatf("%s_byte%0d", tag, j), obs, exp_w);
    end
    obs = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      obs[k] = tx;
    end
    check({tag, "_idle_after"}, obs, 64'hFF);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int c0);
    @(negedge clk_in);
    rx_in = 1'b0;
    c0 = cyc;
    repeat (T) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (T) @(negedge clk_in);
    end
    rx_in = stop;
    repeat (T) @(negedge clk_in);
    rx_in = 1'b1;
    repeat (3 * T) @(negedge clk_in);
  endtask

  logic [7:0] exp_cmd = 8'h00;
  int         exp_pulses = 0;

  task automatic rx_valid(input logic [7:0] b);
    int c0, lat;
    send_byte(b, 1'b1, c0);
    exp_pulses++;
    exp_cmd = b;
    lat = pulse_cyc - c0;
    check("rx_pulse_count", 64'(n_pulse), 64'(exp_pulses));
    check("rx_command", 64'(cmd), 64'(exp_cmd));
    check("rx_pulse_latency", 64'((lat >= 40 && lat <= 42) ? 41 : lat), 64'(41));
    check("rx_busy_rise", 64'((rise_cyc - c0 >= 2 && rise_cyc - c0 <= 4) ? 1 : 0), 64'(1));
    check("rx_busy_before_pulse", 64'(busy_before_pulse), 64'(1));
    check("rx_busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] r1, r2;
    int at, c0;

    data_in   = 16'hA55A;
    data_in50 = 16'h0000;
    do_reset(3);
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_cmd", 64'(cmd), 64'(0));
    check("reset_pulse", 64'(pulse), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));

    wait_tx_start(at);
    check("first_start", 64'(at), 64'(DIV));
    capture_frame(16'hA55A, "frame_a55a");

    r1 = 16'($urandom);
    data_in = r1;
    wait_tx_start(at);
    check("second_start", 64'(at), 64'(2 * DIV));
    data_in = 16'hFFFF;
    capture_frame(r1, "snapshot_hold");

    r2 = 16'($urandom);
    data_in = r2;
    wait_tx_start(at);
    check("third_start", 64'(at), 64'(3 * DIV));
    capture_frame(r2, "frame_rand");

    // ticks every 50 cycles, 80-cycle frames: every other tick starts a frame
    check("u50_frame_count", 64'(starts50.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("u50_start%0d", i),
            64'((i < starts50.size()) ? starts50[i] : -1), 64'(DIV50 + 2 * DIV50 * i));

    for (int i = 0; i < 4; i++) rx_valid(8'($urandom));

    send_byte(8'h31, 1'b0, c0);
    check("frame_err_no_pulse", 64'(n_pulse), 64'(exp_pulses));
    check("frame_err_cmd_kept", 64'(cmd), 64'(exp_cmd));
    check("frame_err_busy", 64'(busy), 64'(0));

    @(negedge clk_in);
    rx_in = 1'b0;
    c0 = cyc;
    @(negedge clk_in);
    rx_in = 1'b1;
    repeat (3 * T) @(negedge clk_in);
    check("glitch_busy_rise", 64'((rise_cyc - c0 >= 2 && rise_cyc - c0 <= 4) ? 1 : 0), 64'(1));
    check("glitch_busy_fall",
          64'((fall_cyc > rise_cyc && fall_cyc - c0 <= T / 2 + 3) ? 1 : 0), 64'(1));
    check("glitch_no_pulse", 64'(n_pulse), 64'(exp_pulses));

    rx_valid(8'h48);

    data_in = 16'h0000;
    do_reset(2);
    exp_cmd = 8'h00;
    check("reset2_cmd_clear", 64'(cmd), 64'(0));
    rx_valid(8'h7E);
    wait_tx_start(at);
    check("start_after_reset", 64'(at), 64'(DIV));
    fork
      send_byte(8'h66, 1'b1, c0);
      begin
        repeat (5 * T) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check("mid_reset_tx", 64'(tx), 64'(1));
        check("mid_reset_cmd", 64'(cmd), 64'(0));
        check("mid_reset_busy", 64'(busy), 64'(0));
      end
    join
    @(negedge clk_in);
    reset = 1'b0;
    cyc_rel = cyc;
    repeat (20) @(negedge clk_in);
    check("mid_reset_no_pulse", 64'(n_pulse), 64'(exp_pulses));
    check("mid_reset_cmd_after", 64'(cmd), 64'(0));
    check("mid_reset_tx_idle", 64'(tx), 64'(1));

    check("no_wide_pulse", 64'(n_wide), 64'(0));
    check("u50_rx_quiet", 64'({cmd50, pulse50, busy50}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
